bus_arbiter: RTL and testbench

- Shares the single external memory bus between the drisc core and a DMA/debug requester.
- Sequences each access as a variable-latency transaction closed by mem_ready.
- Stalls the core (cpu_stall gates the phase generator) until the core's access completes.
- Arbitrates round-robin, lets DMA run bounded bursts, and aborts hung transactions with a timeout.

---
 rtl/bus_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_bus_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Memory bus arbiter: shares one external bus between the core and a DMA/debug
// requester. Round-robin between owners, bounded DMA bursts, and a timeout on
// transactions that never see mem_ready.
module bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned DMA_BURST_MAX  = 4
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cpu_read_i,
    input  logic        cpu_write_i,
    input  logic [31:0] cpu_address_i,
    input  logic [31:0] cpu_data_out_i,
    input  logic [1:0]  cpu_data_size_i,
    output logic [31:0] cpu_data_in_o,
    output logic        cpu_stall_o,
    input  logic        dma_request_i,
    input  logic        dma_write_i,
    input  logic [31:0] dma_address_i,
    input  logic [31:0] dma_data_out_i,
    input  logic [1:0]  dma_data_size_i,
    input  logic        dma_last_i,
    output logic        dma_grant_o,
    output logic        dma_done_o,
    output logic [31:0] dma_data_in_o,
    output logic [31:0] mem_address_o,
    output logic [31:0] mem_data_out_o,
    output logic [1:0]  mem_data_size_o,
    output logic        mem_read_o,
    output logic        mem_write_o,
    input  logic [31:0] mem_data_in_i,
    input  logic        mem_ready_i,
    output logic        bus_error_o
);

    localparam int unsigned BeatW = $clog2(DMA_BURST_MAX + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {StIdle, StMemCpu, StMemDma} state_e;

    // last_owner: 1 = DMA, 0 = CPU
    state_e             state_q, state_d;
    logic               last_owner_q, last_owner_d;
    logic [BeatW-1:0]   beat_q, beat_d;
    logic [TmoW-1:0]    tmo_q, tmo_d;
    logic               served_q, served_d;
    logic [31:0]        cap_addr_q, cap_addr_d;
    logic               cap_write_q, cap_write_d;
    logic [1:0]         cap_size_q, cap_size_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [1:0]         mem_size_q, mem_size_d;
    logic               mem_rd_q, mem_rd_d;
    logic               mem_wr_q, mem_wr_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic [31:0]        dma_rdata_q, dma_rdata_d;

    logic               cpu_req, served_eff, cpu_pending;
    logic               active, timeout, done;
    logic [BeatW-1:0]   beat_inc;
    logic [31:0]        rd_val;

    // Arbitration, transaction sequencing and next-state computation
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        beat_d       = beat_q;
        tmo_d        = tmo_q;
        cap_addr_d   = cap_addr_q;
        cap_write_d  = cap_write_q;
        cap_size_d   = cap_size_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_size_d   = mem_size_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        cpu_rdata_d  = cpu_rdata_q;
        dma_rdata_d  = dma_rdata_q;

        cpu_req = cpu_read_i | cpu_write_i;
        // A served access stays served only while the core presents the same request
        served_eff = served_q & cpu_req & (cpu_address_i == cap_addr_q)
                   & (cpu_write_i == cap_write_q) & (cpu_data_size_i == cap_size_q);
        cpu_pending = cpu_req & ~served_eff;
        served_d    = served_eff;

        // Strobes low in MEM_DMA marks the dead cycle between beats
        active   = mem_rd_q | mem_wr_q;
        timeout  = (state_q != StIdle) & active & ~mem_ready_i
                 & (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));
        done     = (state_q != StIdle) & active & (mem_ready_i | timeout);
        rd_val   = timeout ? 32'h0 : mem_data_in_i;
        beat_inc = beat_q + BeatW'(1);

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (cpu_pending && (!dma_request_i || last_owner_q)) begin
                    mem_addr_d  = cpu_address_i;
                    mem_wdata_d = cpu_data_out_i;
                    mem_size_d  = cpu_data_size_i;
                    mem_wr_d    = cpu_write_i;
                    mem_rd_d    = ~cpu_write_i;
                    cap_addr_d  = cpu_address_i;
                    cap_write_d = cpu_write_i;
                    cap_size_d  = cpu_data_size_i;
                    state_d     = StMemCpu;
                end else if (dma_request_i) begin
                    mem_addr_d  = dma_address_i;
                    mem_wdata_d = dma_data_out_i;
                    mem_size_d  = dma_data_size_i;
                    mem_wr_d    = dma_write_i;
                    mem_rd_d    = ~dma_write_i;
                    beat_d      = '0;
                    state_d     = StMemDma;
                end
            end
            StMemCpu: begin
                if (done) begin
                    if (mem_rd_q) cpu_rdata_d = rd_val;
                    served_d     = 1'b1;
                    last_owner_d = 1'b0;
                    tmo_d        = '0;
                    {mem_addr_d, mem_wdata_d, mem_size_d, mem_rd_d, mem_wr_d} = '0;
                    state_d      = StIdle;
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            StMemDma: begin
                if (done) begin
                    if (mem_rd_q) dma_rdata_d = rd_val;
                    tmo_d = '0;
                    {mem_addr_d, mem_wdata_d, mem_size_d, mem_rd_d, mem_wr_d} = '0;
                    if (dma_last_i || beat_inc == BeatW'(DMA_BURST_MAX) || timeout
                        || !dma_request_i) begin
                        last_owner_d = 1'b1;
                        beat_d       = '0;
                        state_d      = StIdle;
                    end else begin
                        beat_d = beat_inc;
                    end
                end else if (!active) begin
                    tmo_d = '0;
                    if (dma_request_i) begin
                        mem_addr_d  = dma_address_i;
                        mem_wdata_d = dma_data_out_i;
                        mem_size_d  = dma_data_size_i;
                        mem_wr_d    = dma_write_i;
                        mem_rd_d    = ~dma_write_i;
                    end else begin
                        last_owner_d = 1'b1;
                        beat_d       = '0;
                        state_d      = StIdle;
                    end
                end else begin
                    tmo_d = tmo_q + TmoW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered bus outputs, synchronous reset
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            beat_q       <= '0;
            tmo_q        <= '0;
            served_q     <= 1'b0;
            cap_addr_q   <= '0;
            cap_write_q  <= 1'b0;
            cap_size_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_size_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            beat_q       <= beat_d;
            tmo_q        <= tmo_d;
            served_q     <= served_d;
            cap_addr_q   <= cap_addr_d;
            cap_write_q  <= cap_write_d;
            cap_size_q   <= cap_size_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_size_q   <= mem_size_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dma_rdata_q  <= dma_rdata_d;
        end
    end

    // Pulses and stall are suppressed while reset is asserted
    always_comb begin
        cpu_stall_o     = ~reset_i & cpu_pending & ~((state_q == StMemCpu) & done);
        dma_done_o      = ~reset_i & (state_q == StMemDma) & done;
        bus_error_o     = ~reset_i & timeout;
        dma_grant_o     = (state_q == StMemDma);
        cpu_data_in_o   = cpu_rdata_q;
        dma_data_in_o   = dma_rdata_q;
        mem_address_o   = mem_addr_q;
        mem_data_out_o  = mem_wdata_q;
        mem_data_size_o = mem_size_q;
        mem_read_o      = mem_rd_q;
        mem_write_o     = mem_wr_q;
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (TIMEOUT_CYCLES=8, DMA_BURST_MAX=4).
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_address, cpu_data_out, cpu_data_in;
    logic [1:0]  cpu_data_size;
    logic        cpu_stall;
    logic        dma_request, dma_write, dma_last, dma_grant, dma_done;
    logic [31:0] dma_address, dma_data_out, dma_data_in;
    logic [1:0]  dma_data_size;
    logic [31:0] mem_address, mem_data_out, mem_data_in;
    logic [1:0]  mem_data_size;
    logic        mem_read, mem_write, mem_ready, bus_error;

    int n_checks = 0;
    int n_errors = 0;

    bus_arbiter #(.TIMEOUT_CYCLES(8), .DMA_BURST_MAX(4)) dut (
        .clock_i         (clock),
        .reset_i         (reset),
        .cpu_read_i      (cpu_read),
        .cpu_write_i     (cpu_write),
        .cpu_address_i   (cpu_address),
        .cpu_data_out_i  (cpu_data_out),
        .cpu_data_size_i (cpu_data_size),
        .cpu_data_in_o   (cpu_data_in),
        .cpu_stall_o     (cpu_stall),
        .dma_request_i   (dma_request),
        .dma_write_i     (dma_write),
        .dma_address_i   (dma_address),
        .dma_data_out_i  (dma_data_out),
        .dma_data_size_i (dma_data_size),
        .dma_last_i      (dma_last),
        .dma_grant_o     (dma_grant),
        .dma_done_o      (dma_done),
        .dma_data_in_o   (dma_data_in),
        .mem_address_o   (mem_address),
        .mem_data_out_o  (mem_data_out),
        .mem_data_size_o (mem_data_size),
        .mem_read_o      (mem_read),
        .mem_write_o     (mem_write),
        .mem_data_in_i   (mem_data_in),
        .mem_ready_i     (mem_ready),
        .bus_error_o     (bus_error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    // Let combinational outputs settle, sampled mid-cycle
    task automatic settle();
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cpu_read = 0; cpu_write = 0; cpu_address = 0; cpu_data_out = 0; cpu_data_size = 0;
        dma_request = 0; dma_write = 0; dma_address = 0; dma_data_out = 0;
        dma_data_size = 0; dma_last = 0; mem_data_in = 0; mem_ready = 0;
        next();
        reset = 1'b0;
    endtask

    int dones;
    int beat_cycles;
    logic seen_release;
    logic prev_done;

    initial begin
        do_reset();
        next();
        reset = 1'b1;
        settle();
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_mem_addr", mem_address, 32'd0);
        chk("rst_stall", {31'b0, cpu_stall}, 32'd0);
        chk("rst_grant", {31'b0, dma_grant}, 32'd0);
        chk("rst_cpu_data", cpu_data_in, 32'd0);
        next();
        reset = 1'b0;

        // 1: CPU read, ready two cycles after strobe
        cpu_read = 1; cpu_address = 32'h100; cpu_data_size = 2'd2;
        settle();
        chk("t1_idle_stall", {31'b0, cpu_stall}, 32'd1);
        chk("t1_idle_rd", {31'b0, mem_read}, 32'd0);
        next();
        settle();
        chk("t1_rd_c1", {31'b0, mem_read}, 32'd1);
        chk("t1_addr", mem_address, 32'h100);
        chk("t1_size", {30'b0, mem_data_size}, 32'd2);
        chk("t1_stall_c1", {31'b0, cpu_stall}, 32'd1);
        next();
        settle();
        chk("t1_rd_c2", {31'b0, mem_read}, 32'd1);
        next();
        mem_ready = 1; mem_data_in = 32'hDEAD_BEEF;
        settle();
        chk("t1_rd_c3", {31'b0, mem_read}, 32'd1);
        chk("t1_stall_ready", {31'b0, cpu_stall}, 32'd0);
        next();
        mem_ready = 0; cpu_read = 0;
        settle();
        chk("t1_rd_after", {31'b0, mem_read}, 32'd0);
        chk("t1_data", cpu_data_in, 32'hDEAD_BEEF);

        // 2: CPU write ties with DMA after reset
        do_reset();
        cpu_write = 1; cpu_address = 32'h200; cpu_data_out = 32'h1234_5678; cpu_data_size = 2;
        dma_request = 1; dma_write = 0; dma_address = 32'h8000; dma_last = 1;
        settle();
        chk("t2_stall", {31'b0, cpu_stall}, 32'd1);
        next();
        mem_ready = 1;
        settle();
        chk("t2_cpu_wr", {31'b0, mem_write}, 32'd1);
        chk("t2_cpu_addr", mem_address, 32'h200);
        chk("t2_cpu_wdata", mem_data_out, 32'h1234_5678);
        chk("t2_no_grant", {31'b0, dma_grant}, 32'd0);
        next();
        mem_ready = 0;
        settle();
        chk("t2_idle_grant", {31'b0, dma_grant}, 32'd0);
        chk("t2_idle_wr", {31'b0, mem_write}, 32'd0);
        chk("t2_served_nostall", {31'b0, cpu_stall}, 32'd0);
        next();
        cpu_write = 0;
        mem_ready = 1; mem_data_in = 32'hCAFE_0001;
        settle();
        chk("t2_dma_grant", {31'b0, dma_grant}, 32'd1);
        chk("t2_dma_addr", mem_address, 32'h8000);
        chk("t2_dma_done", {31'b0, dma_done}, 32'd1);
        next();
        mem_ready = 0;
        cpu_read = 1; cpu_address = 32'h300;
        settle();
        chk("t2_dma_rdata", dma_data_in, 32'hCAFE_0001);
        chk("t2_grant_off", {31'b0, dma_grant}, 32'd0);
        next();
        mem_ready = 1; mem_data_in = 32'h0BAD_F00D;
        settle();
        chk("t2_tie_cpu_rd", {31'b0, mem_read}, 32'd1);
        chk("t2_tie_cpu_addr", mem_address, 32'h300);
        chk("t2_tie_no_grant", {31'b0, dma_grant}, 32'd0);
        next();
        mem_ready = 0; cpu_read = 0; dma_request = 0; dma_last = 0;
        settle();
        chk("t2_end_rd", {31'b0, mem_read}, 32'd0);

        // 3: six-beat DMA read burst, bursts capped at four beats
        next();
        dma_request = 1; dma_write = 0; dma_last = 0;
        dones = 0; seen_release = 0; prev_done = 0; beat_cycles = 0;
        while (dones < 6 && beat_cycles < 40) begin
            dma_address = 32'h9000 + 32'(dones) * 4;
            mem_data_in = 32'h5000_0000 + 32'(dones);
            dma_last    = (dones == 5);
            mem_ready   = mem_read;
            settle();
            if (prev_done && dones == 4) begin
                chk("t3_release_after4", {31'b0, dma_grant}, 32'd0);
                seen_release = 1;
            end
            prev_done = dma_done;
            if (dma_done) begin
                chk("t3_beat_addr", mem_address, 32'h9000 + 32'(dones) * 4);
                dones++;
            end
            beat_cycles++;
            next();
        end
        mem_ready = 0; dma_request = 0; dma_last = 0;
        chk("t3_beats", 32'(dones), 32'd6);
        chk("t3_released", {31'b0, seen_release}, 32'd1);
        settle();
        chk("t3_final_grant", {31'b0, dma_grant}, 32'd0);
        chk("t3_final_rdata", dma_data_in, 32'h5000_0005);

        // 4: CPU read never readied, aborted on 8th cycle
        next();
        cpu_read = 1; cpu_address = 32'h400; mem_ready = 0;
        next();
        for (int i = 1; i <= 8; i++) begin
            settle();
            chk("t4_rd_held", {31'b0, mem_read}, 32'd1);
            chk("t4_bus_error", {31'b0, bus_error}, (i == 8) ? 32'd1 : 32'd0);
            chk("t4_stall", {31'b0, cpu_stall}, (i == 8) ? 32'd0 : 32'd1);
            next();
        end
        settle();
        chk("t4_data_zero", cpu_data_in, 32'd0);
        chk("t4_stall_after", {31'b0, cpu_stall}, 32'd0);
        chk("t4_rd_after", {31'b0, mem_read}, 32'd0);
        chk("t4_err_after", {31'b0, bus_error}, 32'd0);
        next();
        cpu_read = 0;

        // 5: fetch then load without a gap cycle
        next();
        cpu_read = 1; cpu_address = 32'h10;
        next();
        mem_ready = 1; mem_data_in = 32'h1111_1111;
        settle();
        chk("t5_fetch_addr", mem_address, 32'h10);
        next();
        mem_ready = 0; cpu_address = 32'h2000;
        settle();
        chk("t5_load_stall", {31'b0, cpu_stall}, 32'd1);
        chk("t5_fetch_data", cpu_data_in, 32'h1111_1111);
        next();
        mem_ready = 1; mem_data_in = 32'h2222_2222;
        settle();
        chk("t5_load_rd", {31'b0, mem_read}, 32'd1);
        chk("t5_load_addr", mem_address, 32'h2000);
        next();
        mem_ready = 0;
        settle();
        chk("t5_load_data", cpu_data_in, 32'h2222_2222);
        chk("t5_hold_nostall", {31'b0, cpu_stall}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            next();
            settle();
            chk("t5_no_reissue", {31'b0, mem_read}, 32'd0);
        end
        next();
        cpu_read = 0;

        // 6: reset in the middle of a DMA beat
        dma_request = 1; dma_address = 32'hA000; dma_last = 0;
        next();
        reset = 1; mem_ready = 1;
        settle();
        chk("t6_grant_before", {31'b0, dma_grant}, 32'd1);
        chk("t6_no_done", {31'b0, dma_done}, 32'd0);
        chk("t6_no_err", {31'b0, bus_error}, 32'd0);
        next();
        reset = 0; mem_ready = 0;
        cpu_read = 1; cpu_address = 32'h500;
        settle();
        chk("t6_rd_low", {31'b0, mem_read}, 32'd0);
        chk("t6_addr_zero", mem_address, 32'd0);
        chk("t6_grant_low", {31'b0, dma_grant}, 32'd0);
        chk("t6_done_low", {31'b0, dma_done}, 32'd0);
        next();
        settle();
        chk("t6_tie_cpu", mem_address, 32'h500);
        chk("t6_tie_no_grant", {31'b0, dma_grant}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
